// File: rtl/if_id_skid.sv
// if_id_skid: fetch-to-decode pipeline register with a 2-entry skid buffer and flush/hold control.
// Optional stall counter output stall_cnt_o enabled by defining IF_ID_SKID_PERF_EN.
module if_id_skid #(
  parameter int InstW = 32,
  parameter int AddrW = 32,
  parameter int HoldW = 3,
  parameter logic [InstW-1:0] NopInst = 32'h0000_0013,
  parameter logic [HoldW-1:0] HoldIf = 3'b010,
  parameter logic [HoldW-1:0] PipeClear = 3'b111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [InstW-1:0] inst_i,
  input  logic [AddrW-1:0] inst_addr_i,
  input  logic [HoldW-1:0] hold_flag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [InstW-1:0] inst_o,
`ifdef IF_ID_SKID_PERF_EN
  output logic [31:0]      stall_cnt_o,
`endif
  output logic [AddrW-1:0] inst_addr_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  state_e state_q;
  logic [InstW-1:0] head_inst_q, skid_inst_q;
  logic [AddrW-1:0] head_addr_q, skid_addr_q;
  logic flush, blk, push, pop;
  assign flush = hold_flag_i == PipeClear;
  assign blk = (hold_flag_i >= HoldIf) && !flush;
  assign ready_o = state_q != TWO;
  assign valid_o = state_q == ONE || state_q == TWO;
  assign push = valid_i & ready_o;
  assign pop = valid_o & ready_i & ~blk;
  assign inst_o = valid_o ? head_inst_q : NopInst;
  assign inst_addr_o = head_addr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_inst_q <= NopInst;
      head_addr_q <= '0;
      skid_inst_q <= '0;
      skid_addr_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_inst_q <= inst_i;
          head_addr_q <= inst_addr_i;
          state_q <= ONE;
        end
        ONE: if (push && pop) begin
          head_inst_q <= inst_i;
          head_addr_q <= inst_addr_i;
        end else if (push) begin
          skid_inst_q <= inst_i;
          skid_addr_q <= inst_addr_i;
          state_q <= TWO;
        end else if (pop) begin
          state_q <= EMPTY;
        end
        TWO: if (pop) begin
          head_inst_q <= skid_inst_q;
          head_addr_q <= skid_addr_q;
          state_q <= ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else if (((valid_o & ~pop) | (valid_i & ~ready_o)) && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: directed checks of the if_id_skid skid buffer against hand-computed values.
module tb_if_id_skid;
  localparam logic [2:0] HoldIf = 3'b010;
  localparam logic [2:0] PipeClear = 3'b111;
  localparam logic [31:0] Nop = 32'h0000_0013;
  logic clk = 0, rst = 1, valid_i = 0, ready_i = 0, ready_o, valid_o;
  logic [31:0] inst_i = 0, inst_addr_i = 0, inst_o, inst_addr_o;
  logic [2:0] hold_flag_i = 0;
  int n_chk = 0, n_fail = 0;
`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cnt_o;
`endif
  if_id_skid dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .hold_flag_i(hold_flag_i),
    .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
`ifdef IF_ID_SKID_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .inst_addr_o(inst_addr_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr);
    valid_i = v;
    inst_i = inst;
    inst_addr_i = addr;
  endtask
  initial begin
    #3;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_inst", inst_o, Nop);
    chk("rst_addr", inst_addr_o, 0);
`ifdef IF_ID_SKID_PERF_EN
    chk("rst_cnt", stall_cnt_o, 0);
`endif
    @(negedge clk);
    rst = 0;
    drive(1, 32'h0010_0093, 32'h100);
    ready_i = 1;
    tick;
    drive(0, 0, 0);
    chk("single_valid", valid_o, 1);
    chk("single_inst", inst_o, 32'h0010_0093);
    chk("single_addr", inst_addr_o, 32'h100);
    tick;
    chk("single_empty", valid_o, 0);
    chk("single_nop", inst_o, Nop);
    chk("single_keep_addr", inst_addr_o, 32'h100);
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h1000 + i, 4 * i);
      tick;
      chk("stream_ready", ready_o, 1);
      chk("stream_valid", valid_o, 1);
      chk("stream_addr", inst_addr_o, 4 * i);
      chk("stream_inst", inst_o, 32'h1000 + i);
    end
    drive(0, 0, 0);
    tick;
    chk("stream_drain", valid_o, 0);
    ready_i = 0;
    drive(1, 32'hA, 32'h20);
    tick;
    drive(1, 32'hB, 32'h24);
    tick;
    chk("bp_full", ready_o, 0);
    chk("bp_head", inst_addr_o, 32'h20);
    drive(1, 32'hC, 32'h28);
    tick;
    chk("bp_stall_ready", ready_o, 0);
    chk("bp_stall_head", inst_o, 32'hA);
    ready_i = 1;
    tick;
    chk("bp_b_addr", inst_addr_o, 32'h24);
    chk("bp_b_ready", ready_o, 1);
    tick;
    chk("bp_c_inst", inst_o, 32'hC);
    chk("bp_c_addr", inst_addr_o, 32'h28);
    drive(0, 0, 0);
    tick;
    chk("bp_drain", valid_o, 0);
    ready_i = 0;
    drive(1, 32'hD, 32'h30);
    tick;
    drive(1, 32'hE, 32'h34);
    tick;
    drive(0, 0, 0);
    hold_flag_i = HoldIf;
    ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_valid", valid_o, 1);
      chk("hold_addr", inst_addr_o, 32'h30);
      chk("hold_ready", ready_o, 0);
    end
    hold_flag_i = 0;
    tick;
    chk("hold_rel_e", inst_addr_o, 32'h34);
    tick;
    chk("hold_rel_empty", valid_o, 0);
    ready_i = 0;
    drive(1, 32'hF, 32'h40);
    tick;
    drive(1, 32'h11, 32'h44);
    tick;
    drive(1, 32'h12, 32'h48);
    hold_flag_i = PipeClear;
    tick;
    hold_flag_i = 0;
    drive(0, 0, 0);
    chk("flush2_valid", valid_o, 0);
    chk("flush2_ready", ready_o, 1);
    chk("flush2_inst", inst_o, Nop);
    tick;
    chk("flush2_gone", valid_o, 0);
    drive(1, 32'h14, 32'h50);
    tick;
    drive(1, 32'h15, 32'h54);
    hold_flag_i = PipeClear;
    tick;
    hold_flag_i = 0;
    drive(0, 0, 0);
    chk("flush1_valid", valid_o, 0);
    tick;
    chk("flush1_push_dropped", valid_o, 0);
    drive(1, 32'h16, 32'h60);
    tick;
    drive(0, 0, 0);
    chk("ar_pre_valid", valid_o, 1);
    chk("ar_pre_addr", inst_addr_o, 32'h60);
    #2 rst = 1;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_addr", inst_addr_o, 0);
    chk("ar_ready", ready_o, 1);
    chk("ar_inst", inst_o, Nop);
`ifdef IF_ID_SKID_PERF_EN
    chk("ar_cnt", stall_cnt_o, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
